// File: rtl/pair_triple_vote_arbiter.sv
// Round-robin front end sharing one 2-of-3 majority detector among NREQ requesters.
// Each granted sample is voted one cycle after acceptance and held until the consumer takes it.
module pair_triple_vote_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [3*NREQ-1:0] req_bits,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic              resp_vote,
  output logic [IDW-1:0]    resp_id,
  output logic [CNTW-1:0]   disagree_cnt,
  input  logic              cnt_clr
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam int             IDX     = IDW + 1;
  localparam logic [IDW:0]   NREQ_X  = IDX'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic [IDW:0]   scan;
  logic [2:0]     bits_p0;
  logic [IDW-1:0] id_p0;

  function automatic logic vote3(input logic [2:0] b);
    return (b[0] & b[1]) | ((b[0] | b[1]) & b[2]);
  endfunction

  function automatic logic is_split(input logic [2:0] b);
    return (b != 3'b000) && (b != 3'b111);
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + 1'b1;
  endfunction

  // Scan from the farthest slot back to ptr so the nearest requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr} + IDX'(k);
      if (scan >= NREQ_X) scan = scan - NREQ_X;
      if (req_val[scan[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (rst_n && (state == IDLE) && gnt_vld) req_rdy[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (resp_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign resp_val = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      bits_p0      <= '0;
      id_p0        <= '0;
      resp_vote    <= 1'b0;
      resp_id      <= '0;
      disagree_cnt <= '0;
    end else begin
      state <= state_nxt;
      // p0: capture the granted sample
      if ((state == IDLE) && gnt_vld) begin
        bits_p0 <= req_bits[3*gnt_id +: 3];
        id_p0   <= gnt_id;
      end
      // p1: shared detector result
      if (state == EVAL) begin
        resp_vote <= vote3(bits_p0);
        resp_id   <= id_p0;
      end
      if ((state == RESP) && resp_rdy) ptr <= next_id(resp_id);
      if (cnt_clr)
        disagree_cnt <= '0;
      else if ((state == EVAL) && is_split(bits_p0))
        disagree_cnt <= sat_inc(disagree_cnt);
    end
  end

endmodule
